// File: rtl/sfq_line_pkg.sv
// -----------------------------------------------------------------------------
// sfq_line_pkg
// Shared definitions for the SFQ line arbiter:
//   - default parameter values for the arbiter,
//   - FSM state encodings (INIT / IDLE / GAP),
//   - a clog2 helper used to size ports and counters (never returns < 1, so a
//     one-entry configuration still gets a legal one-bit vector).
// -----------------------------------------------------------------------------
package sfq_line_pkg;

  // Default configuration of one shared SFQ buffer line.
  localparam int DEF_N_REQ        = 4;   // requesters sharing the line
  localparam int DEF_INIT_CYCLES  = 8;   // quiet period after reset (cell begin_time)
  localparam int DEF_MIN_GAP      = 4;   // min cycles between pulses (cell hold)
  localparam int DEF_MAX_INFLIGHT = 3;   // max pulses awaiting their echo
  localparam int DEF_TIMEOUT      = 15;  // echo wait before in-flight count is flushed

  // FSM state encodings.
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Ceiling log2, clamped to a minimum of 1 bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sfq_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sfq_rr_arbiter
// Purely combinational round-robin priority pick. The search starts at ptr and
// walks upward (wrapping at N_REQ); the first set request wins.
//
// Ports:
//   req         in  N_REQ  request vector
//   ptr         in  ID_W   index with highest priority this cycle (< N_REQ)
//   enable      in  1      when low no grant is produced
//   grant       out N_REQ  one-hot grant (all zero when nothing is granted)
//   grant_idx   out ID_W   index of the granted requester (0 when none)
//   grant_valid out 1      a grant was produced
// -----------------------------------------------------------------------------
module sfq_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_valid
);

  // cand_idx[k] is the requester examined at search distance k from ptr.
  logic [ID_W-1:0]  cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum = {1'b0, ptr} + (ID_W+1)'(gi);
      // ptr < N_REQ and gi < N_REQ, so one conditional subtract is a full modulo.
      assign cand_idx[gi] = (sum >= (ID_W+1)'(N_REQ)) ?
                            ID_W'(sum - (ID_W+1)'(N_REQ)) : sum[ID_W-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    // Walk from the farthest candidate down so the nearest one overrides.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (enable && cand_req[i]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
    grant = '0;
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sfq_line_arbiter.sv
// -----------------------------------------------------------------------------
// sfq_line_arbiter
// Shares one transition-encoded SFQ buffer line among N_REQ requesters.
// Each toggle of line_tx is one pulse; each toggle of line_rx is its echo.
// The controller enforces a startup quiet period, a minimum spacing between
// pulses, and a cap on pulses still waiting for their echo. A watchdog flushes
// the in-flight count if echoes stop arriving.
//
// Ports:
//   clk          in   1            clock
//   rst_n        in   1            asynchronous active-low reset
//   req_valid    in   N_REQ        per-requester pulse request
//   req_ready    out  N_REQ        one-hot grant; transfer on valid & ready
//   line_tx      out  1            toggle-encoded pulse to the buffer line
//   line_rx      in   1            toggle-encoded echo (already clk-synchronous)
//   grant_id     out  clog2(N_REQ) index of the last granted requester
//   inflight     out  clog2(MAX_INFLIGHT+1) pulses awaiting an echo
//   busy         out  1            not idle or pulses still in flight
//   err_clr      in   1            clears both sticky errors (set wins)
//   err_timeout  out  1            sticky: an echo did not arrive in time
//   err_spurious out  1            sticky: an echo arrived with nothing in flight
// -----------------------------------------------------------------------------
module sfq_line_arbiter
  import sfq_line_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int MIN_GAP      = DEF_MIN_GAP,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  output logic                             line_tx,
  input  logic                             line_rx,
  output logic [clog2(N_REQ)-1:0]          grant_id,
  output logic [clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                             busy,
  input  logic                             err_clr,
  output logic                             err_timeout,
  output logic                             err_spurious
);

  localparam int ID_W   = clog2(N_REQ);
  localparam int IF_W   = clog2(MAX_INFLIGHT + 1);
  localparam int INIT_W = clog2(INIT_CYCLES + 1);
  localparam int GAP_W  = clog2(MIN_GAP + 1);
  localparam int WD_W   = clog2(TIMEOUT + 1);

  logic [1:0]        state_reg,        state_next;
  logic [INIT_W-1:0] init_cnt_reg,     init_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg,      gap_cnt_next;
  logic [ID_W-1:0]   rr_ptr_reg,       rr_ptr_next;
  logic [ID_W-1:0]   grant_id_reg,     grant_id_next;
  logic              line_tx_reg,      line_tx_next;
  logic              rx_prev_reg,      rx_prev_next;
  logic [IF_W-1:0]   inflight_reg,     inflight_next;
  logic [WD_W-1:0]   wd_reg,           wd_next;
  logic              err_timeout_reg,  err_timeout_next;
  logic              err_spurious_reg, err_spurious_next;

  logic              arb_en;
  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic              fire;
  logic              echo;
  logic              wd_inc;
  logic              timeout_hit;

  // Grants are only offered in IDLE and while there is room for another pulse.
  assign arb_en = (state_reg == ST_IDLE) && (inflight_reg < IF_W'(MAX_INFLIGHT));

  sfq_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req         (req_valid),
    .ptr         (rr_ptr_reg),
    .enable      (arb_en),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (fire)
  );

  // Echo detection is blind during INIT so stale toggles from before reset
  // (rx_prev still tracks the line) never count against new pulses.
  assign echo = (state_reg != ST_INIT) && (line_rx != rx_prev_reg);

  // The watchdog measures quiet time since the last fire or echo while pulses
  // are outstanding, so a timeout is always TIMEOUT cycles after activity.
  assign wd_inc      = (inflight_reg != '0) && !echo && !fire;
  assign timeout_hit = wd_inc && (wd_reg == WD_W'(TIMEOUT - 1));

  // Line FSM: quiet period, grant, and pulse spacing.
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_id_next = grant_id_reg;
    line_tx_next  = line_tx_reg;
    rx_prev_next  = line_rx;

    case (state_reg)
      ST_INIT: begin
        if (init_cnt_reg == INIT_W'(INIT_CYCLES - 1)) begin
          state_next    = ST_IDLE;
          init_cnt_next = '0;
        end else begin
          init_cnt_next = init_cnt_reg + INIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (fire) begin
          line_tx_next  = ~line_tx_reg;
          grant_id_next = arb_idx;
          rr_ptr_next   = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
          // With MIN_GAP==1 the next grant may follow immediately, so GAP is skipped.
          if (MIN_GAP > 1) begin
            state_next   = ST_GAP;
            gap_cnt_next = GAP_W'(MIN_GAP - 1);
          end
        end
      end
      ST_GAP: begin
        // Leaving GAP on the count reaching zero spaces grants MIN_GAP cycles apart.
        if (gap_cnt_reg <= GAP_W'(1)) begin
          state_next   = ST_IDLE;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      default: begin
        state_next    = ST_INIT;
        init_cnt_next = '0;
      end
    endcase
  end

  // In-flight accounting, watchdog and sticky errors.
  always_comb begin
    inflight_next     = inflight_reg;
    wd_next           = wd_reg;
    err_timeout_next  = err_timeout_reg;
    err_spurious_next = err_spurious_reg;

    if (timeout_hit) begin
      inflight_next = '0;
      wd_next       = '0;
    end else if (fire || echo) begin
      wd_next = '0;
      if (fire && !echo) begin
        inflight_next = inflight_reg + IF_W'(1);
      end else if (echo && !fire && (inflight_reg != '0)) begin
        inflight_next = inflight_reg - IF_W'(1);
      end
    end else if (wd_inc) begin
      wd_next = wd_reg + WD_W'(1);
    end else begin
      wd_next = '0;
    end

    // Clear first so that a set in the same cycle overrides it.
    if (err_clr) begin
      err_timeout_next  = 1'b0;
      err_spurious_next = 1'b0;
    end
    if (timeout_hit) begin
      err_timeout_next = 1'b1;
    end
    if (echo && (inflight_reg == '0)) begin
      err_spurious_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_INIT;
      init_cnt_reg     <= '0;
      gap_cnt_reg      <= '0;
      rr_ptr_reg       <= '0;
      grant_id_reg     <= '0;
      line_tx_reg      <= 1'b0;
      rx_prev_reg      <= 1'b0;
      inflight_reg     <= '0;
      wd_reg           <= '0;
      err_timeout_reg  <= 1'b0;
      err_spurious_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      init_cnt_reg     <= init_cnt_next;
      gap_cnt_reg      <= gap_cnt_next;
      rr_ptr_reg       <= rr_ptr_next;
      grant_id_reg     <= grant_id_next;
      line_tx_reg      <= line_tx_next;
      rx_prev_reg      <= rx_prev_next;
      inflight_reg     <= inflight_next;
      wd_reg           <= wd_next;
      err_timeout_reg  <= err_timeout_next;
      err_spurious_reg <= err_spurious_next;
    end
  end

  assign req_ready    = arb_grant;
  assign line_tx      = line_tx_reg;
  assign grant_id     = grant_id_reg;
  assign inflight     = inflight_reg;
  assign err_timeout  = err_timeout_reg;
  assign err_spurious = err_spurious_reg;
  // Built from registers only; no path from req_valid.
  assign busy         = (state_reg != ST_IDLE) || (inflight_reg != '0);

endmodule

// File: tb/tb_sfq_line_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sfq_line_arbiter
// Directed bench for sfq_line_arbiter. A behavioural model (cycle counts since
// reset, time of the last fire, a round-robin search, an in-flight count and a
// quiet-time count) predicts every output each cycle; literal expectations pin
// the headline timing numbers.
// -----------------------------------------------------------------------------
module tb_sfq_line_arbiter;

  localparam int N_REQ        = 4;
  localparam int INIT_CYCLES  = 8;
  localparam int MIN_GAP      = 4;
  localparam int MAX_INFLIGHT = 3;
  localparam int TIMEOUT      = 15;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic       line_tx;
  logic       line_rx;
  logic [1:0] grant_id;
  logic [1:0] inflight;
  logic       busy;
  logic       err_clr;
  logic       err_timeout;
  logic       err_spurious;

  sfq_line_arbiter #(
    .N_REQ        (N_REQ),
    .INIT_CYCLES  (INIT_CYCLES),
    .MIN_GAP      (MIN_GAP),
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .line_tx      (line_tx),
    .line_rx      (line_rx),
    .grant_id     (grant_id),
    .inflight     (inflight),
    .busy         (busy),
    .err_clr      (err_clr),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int gcyc  = 0;
  bit echo_en;
  logic [2:0] tx_hist;
  logic tx_seen;

  // Behavioural model state.
  int m_cyc;     // clock edges since reset release
  int m_last;    // m_cyc value in the cycle of the last grant
  int m_ptr;     // requester searched first
  int m_infl;    // pulses awaiting echo
  int m_quiet;   // cycles with pulses outstanding and no activity
  bit m_eto;
  bit m_esp;
  bit m_tx;
  int m_gid;
  bit m_rxp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, gcyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_last  = -MIN_GAP;
    m_ptr   = 0;
    m_infl  = 0;
    m_quiet = 0;
    m_eto   = 0;
    m_esp   = 0;
    m_tx    = 0;
    m_gid   = 0;
    m_rxp   = 0;
  endtask

  function automatic bit m_open();
    return (m_cyc >= INIT_CYCLES) && ((m_cyc - m_last) >= MIN_GAP) && (m_infl < MAX_INFLIGHT);
  endfunction

  function automatic int m_winner(input logic [3:0] rv);
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % N_REQ;
      if (rv[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit echo;
    bit fire;
    bit spur;
    bit to;
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    echo = (m_cyc >= INIT_CYCLES) && (line_rx != m_rxp);
    w    = m_open() ? m_winner(req_valid) : -1;
    fire = (w >= 0);
    spur = echo && (m_infl == 0);
    to   = 0;
    if (m_infl > 0 && !echo && !fire) begin
      m_quiet++;
      if (m_quiet >= TIMEOUT) to = 1;
    end else begin
      m_quiet = 0;
    end
    if (to) begin
      m_infl  = 0;
      m_quiet = 0;
    end else if (fire && !echo) begin
      m_infl++;
    end else if (echo && !fire && m_infl > 0) begin
      m_infl--;
    end
    m_esp = spur | (m_esp & !err_clr);
    m_eto = to | (m_eto & !err_clr);
    if (fire) begin
      m_tx   = !m_tx;
      m_gid  = w;
      m_ptr  = (w + 1) % N_REQ;
      m_last = m_cyc;
    end
    m_rxp = line_rx;
    if (m_cyc < 1000000) m_cyc++;
  endtask

  task automatic cmp_model();
    logic [3:0] exp_ready;
    bit exp_busy;
    int w;
    exp_ready = '0;
    w = m_open() ? m_winner(req_valid) : -1;
    if (w >= 0) exp_ready[w] = 1'b1;
    exp_busy = (m_cyc < INIT_CYCLES) || ((m_cyc - m_last) < MIN_GAP) || (m_infl != 0);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("line_tx", 32'(line_tx), 32'(m_tx));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("inflight", 32'(inflight), 32'(m_infl));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("err_timeout", 32'(err_timeout), 32'(m_eto));
    chk("err_spurious", 32'(err_spurious), 32'(m_esp));
  endtask

  // One clock: compare on the falling edge, advance model on the rising edge,
  // then return 1 time unit later with the echo responder applied.
  task automatic tick();
    @(negedge clk);
    cmp_model();
    @(posedge clk);
    model_step();
    #1;
    gcyc++;
    tx_hist = {tx_hist[1:0], line_tx};
    // Echo lands at the DUT two edges after the line toggle.
    if (echo_en && (tx_hist[1] != tx_hist[2])) line_rx = ~line_rx;
    if (line_tx != tx_seen) begin
      tx_seen = line_tx;
      $display("cycle %0d: line_tx=%0b grant_id=%0d inflight=%0d", gcyc, line_tx, grant_id, inflight);
    end
  endtask

  task automatic wait_toggle(output int t);
    logic start;
    bit seen;
    start = line_tx;
    seen  = 0;
    t     = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (line_tx != start) begin
        seen = 1;
        t    = gcyc;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_toggle @cycle %0d: got no line_tx toggle, want one within 30 cycles", gcyc);
    end
  endtask

  initial begin
    int first;
    int t;
    int prev_t;
    int exp_ids [4];
    exp_ids = '{1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    line_rx   = 1'b0;
    err_clr   = 1'b0;
    echo_en   = 1;
    tx_hist   = 3'b000;
    tx_seen   = 1'b0;
    model_reset();
    repeat (3) tick();

    // Reset state.
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_line_tx", 32'(line_tx), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);

    // Quiet period, then first grant to req0 in cycle 9, toggle in cycle 10.
    req_valid = 4'b1111;
    rst_n     = 1'b1;
    first     = 0;
    for (int c = 1; c <= 20; c++) begin
      if (req_ready != 4'b0000) begin
        first = c;
        break;
      end
      tick();
    end
    chk("first_grant_cycle", 32'(first), 32'd9);
    chk("first_ready", 32'(req_ready), 32'h1);
    tick();
    chk("first_toggle", 32'(line_tx), 32'h1);
    chk("first_grant_id", 32'(grant_id), 32'h0);
    prev_t = gcyc;

    // Continuous requests with echoes: order 1,2,3,0 every MIN_GAP cycles.
    for (int i = 0; i < 4; i++) begin
      wait_toggle(t);
      chk("rr_spacing", 32'(t - prev_t), 32'd4);
      chk("rr_order", 32'(grant_id), 32'(exp_ids[i]));
      chk("rr_inflight", 32'(inflight), 32'h1);
      prev_t = t;
    end
    tick();
    tick();
    chk("echo_drain", 32'(inflight), 32'h0);
    chk("echo_no_err", 32'({err_timeout, err_spurious}), 32'h0);

    // No echoes: three more pulses fill the line, then the watchdog flushes.
    echo_en = 0;
    for (int i = 0; i < 3; i++) wait_toggle(t);
    chk("full_inflight", 32'(inflight), 32'd3);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 5) begin
        chk("full_no_ready", 32'(req_ready), 32'h0);
        chk("full_hold", 32'(inflight), 32'd3);
      end
      if (k == 14) chk("wd_not_yet", 32'(err_timeout), 32'h0);
    end
    chk("wd_fired", 32'(err_timeout), 32'h1);
    chk("wd_flush", 32'(inflight), 32'h0);
    chk("wd_resume_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("resume_grant_id", 32'(grant_id), 32'h0);
    chk("resume_inflight", 32'(inflight), 32'h1);
    line_rx = ~line_rx;
    tick();
    chk("manual_echo", 32'(inflight), 32'h0);
    chk("manual_echo_ok", 32'(err_spurious), 32'h0);

    // Spurious echo with nothing in flight.
    repeat (4) tick();
    line_rx = ~line_rx;
    tick();
    chk("spurious_set", 32'(err_spurious), 32'h1);

    // Clear both sticky errors.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_spurious", 32'(err_spurious), 32'h0);
    chk("clr_timeout", 32'(err_timeout), 32'h0);

    // Set wins over a simultaneous clear.
    line_rx = ~line_rx;
    tick();
    chk("spurious_again", 32'(err_spurious), 32'h1);
    line_rx = ~line_rx;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("set_wins", 32'(err_spurious), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_after", 32'(err_spurious), 32'h0);

    // Two pulses in flight, then reset in the middle of the gap.
    repeat (3) tick();
    req_valid = 4'b1111;
    wait_toggle(t);
    wait_toggle(t);
    chk("pre_rst_inflight", 32'(inflight), 32'd2);
    chk("pre_rst_grant_id", 32'(grant_id), 32'd2);
    chk("pre_rst_line_tx", 32'(line_tx), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_req_ready", 32'(req_ready), 32'h0);
    chk("async_line_tx", 32'(line_tx), 32'h0);
    chk("async_inflight", 32'(inflight), 32'h0);
    chk("async_grant_id", 32'(grant_id), 32'h0);
    chk("async_busy", 32'(busy), 32'h1);
    req_valid = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    line_rx = ~line_rx;          // late echo during INIT
    repeat (10) tick();
    chk("late_echo_ignored", 32'(err_spurious), 32'h0);
    chk("late_echo_inflight", 32'(inflight), 32'h0);
    chk("post_init_busy", 32'(busy), 32'h0);
    req_valid = 4'b1111;
    #1;
    chk("ptr_reset_ready", 32'(req_ready), 32'h1);
    wait_toggle(t);
    chk("post_rst_grant", 32'(grant_id), 32'h0);
    req_valid = 4'b0000;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not complete, want completion");
    $fatal(1);
  end

endmodule
